// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and default frame geometry shared by the SPI master/slave blocks.
`default_nettype none

package spi_pkg;

  localparam int HALF_PERIOD_DEF = 8;
  localparam int NUM_BYTES_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    SCK_HI = 2'd2,
    SCK_LO = 2'd3
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit, reset to 0.
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_rx.sv
// spi_master_rx: mode-0 style SPI read master; clocks NUM_BYTES bytes in per frame,
// sampling synchronised MISO on each falling SCK edge, MSB first.
`default_nettype none

module spi_master_rx
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int NUM_BYTES   = NUM_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       MISO,
  output logic       SCK,
  output logic       SS,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] rx_index,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [6:0] LAST_BIT = 7'(8 * NUM_BYTES - 1);

  spi_state_t state, state_n;
  logic [7:0] hp_cnt, hp_cnt_n;
  logic [6:0] bit_cnt, bit_cnt_n;
  logic [6:0] shreg;
  logic       sck_n, ss_n, busy_n, done_n;
  logic       sample;
  logic       hp_end;
  logic       miso_s;

  sync_2ff u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d   (MISO),
    .q   (miso_s)
  );

  assign hp_end = (hp_cnt == HP_LAST);

  always_comb begin
    state_n   = state;
    hp_cnt_n  = hp_cnt;
    bit_cnt_n = bit_cnt;
    sck_n     = SCK;
    ss_n      = SS;
    busy_n    = busy;
    done_n    = 1'b0;
    sample    = 1'b0;
    case (state)
      // done is still high in the first IDLE cycle, so a start there is refused
      IDLE: begin
        if (start && !done) begin
          state_n   = SETUP;
          hp_cnt_n  = 8'd0;
          bit_cnt_n = 7'd0;
          ss_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end
      SETUP: begin
        if (hp_end) begin
          state_n  = SCK_HI;
          hp_cnt_n = 8'd0;
          sck_n    = 1'b1;
        end else begin
          hp_cnt_n = hp_cnt + 8'd1;
        end
      end
      SCK_HI: begin
        if (hp_end) begin
          state_n  = SCK_LO;
          hp_cnt_n = 8'd0;
          sck_n    = 1'b0;
          sample   = 1'b1;
        end else begin
          hp_cnt_n = hp_cnt + 8'd1;
        end
      end
      SCK_LO: begin
        if (hp_end) begin
          hp_cnt_n = 8'd0;
          if (bit_cnt == LAST_BIT) begin
            state_n = IDLE;
            ss_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n   = SCK_HI;
            sck_n     = 1'b1;
            bit_cnt_n = bit_cnt + 7'd1;
          end
        end else begin
          hp_cnt_n = hp_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hp_cnt   <= 8'd0;
      bit_cnt  <= 7'd0;
      shreg    <= 7'd0;
      SCK      <= 1'b0;
      SS       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'd0;
      rx_index <= 4'd0;
    end else begin
      state    <= state_n;
      hp_cnt   <= hp_cnt_n;
      bit_cnt  <= bit_cnt_n;
      SCK      <= sck_n;
      SS       <= ss_n;
      busy     <= busy_n;
      done     <= done_n;
      rx_valid <= sample && (bit_cnt[2:0] == 3'd7);
      if (sample) begin
        shreg <= {shreg[5:0], miso_s};
      end
      // shreg holds the first seven bits; the eighth comes straight from the synchroniser
      if (sample && (bit_cnt[2:0] == 3'd7)) begin
        rx_data  <= {shreg, miso_s};
        rx_index <= bit_cnt[6:3];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_rx.sv
// tb_spi_master_rx: randomized frames against a behavioural SPI slave and a frame-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master_rx;

  localparam int HP        = 8;
  localparam int NB        = 16;
  localparam int NBITS     = 8 * NB;
  localparam int FRAME_LOW = HP * (1 + 16 * NB);
  localparam int RUNS      = 16 * NB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       miso;
  logic       SCK, SS, rx_valid, busy, done;
  logic [7:0] rx_data;
  logic [3:0] rx_index;

  always #5 clk = ~clk;

  spi_master_rx #(.HALF_PERIOD(HP), .NUM_BYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .MISO     (miso),
    .SCK      (SCK),
    .SS       (SS),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_index (rx_index),
    .busy     (busy),
    .done     (done)
  );

  // Slave: presents bit k (MSB first) and advances on every falling SCK while selected.
  logic [NBITS-1:0] slave_bits = '0;
  logic [7:0]       slave_k = 8'd0;
  logic [7:0]       exp_bytes [NB];

  always @(posedge SS or negedge SCK) begin
    if (SS) slave_k = 8'd0;
    else    slave_k = slave_k + 8'd1;
  end

  assign miso = (int'(slave_k) < NBITS) ? slave_bits[slave_k[6:0]] : 1'b0;

  // Monitor: cumulative frame statistics sampled just after the falling clock edge.
  int         ss_low_total = 0, busy_total = 0, rxv_total = 0, done_total = 0;
  int         done_bad = 0, rxv_double = 0, runs_total = 0, bad_runs = 0;
  int         sck_tog_ss_high = 0, last_gap = 0, run_len = 0;
  bit         run_valid = 1'b0;
  logic       p_sck = 1'b0, p_ss = 1'b1, p_rxv = 1'b0;
  logic [7:0] got_data [0:1023];
  logic [3:0] got_idx  [0:1023];

  always @(negedge clk) begin
    #1;
    if (!SS) ss_low_total++;
    if (busy) busy_total++;
    if (rx_valid) begin
      got_data[rxv_total] = rx_data;
      got_idx[rxv_total]  = rx_index;
      rxv_total++;
      if (p_rxv) rxv_double++;
    end
    if (done) begin
      done_total++;
      if (!SS || busy || p_ss) done_bad++;
    end
    if (SS && p_ss && (SCK != p_sck)) sck_tog_ss_high++;
    if (rst) begin
      run_valid = 1'b0;
      run_len   = 0;
    end else if ((SCK != p_sck) || (SS != p_ss)) begin
      if (run_valid && !p_ss) begin
        runs_total++;
        if (run_len != HP) bad_runs++;
      end
      if (run_valid && p_ss && !SS) last_gap = run_len;
      run_valid = 1'b1;
      run_len   = 1;
    end else begin
      run_len++;
    end
    p_sck = SCK;
    p_ss  = SS;
    p_rxv = rx_valid;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_slave();
    for (int i = 0; i < NB; i++)
      for (int b = 0; b < 8; b++)
        slave_bits[i * 8 + b] = exp_bytes[i][7 - b];
  endtask

  task automatic random_bytes();
    for (int i = 0; i < NB; i++) exp_bytes[i] = 8'($urandom);
  endtask

  task automatic run_frames(input string name, input int nframes, input bit hold, input bit pulses);
    int b_ss, b_busy, b_rxv, b_done, b_runs, b_bad, b_tog, b_dbad, b_dbl, cyc, k;
    b_ss = ss_low_total; b_busy = busy_total; b_rxv = rxv_total; b_done = done_total;
    b_runs = runs_total; b_bad = bad_runs; b_tog = sck_tog_ss_high;
    b_dbad = done_bad; b_dbl = rxv_double;
    load_slave();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_accept"}, {30'd0, SS, busy}, 32'd1);
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int f = 0; f < nframes; f++) begin
      if (f > 0) @(negedge clk);
      cyc = 0;
      while (!done && cyc < 3 * FRAME_LOW) begin
        @(negedge clk);
        cyc++;
        if (pulses) start = ($urandom_range(0, 40) == 0);
      end
      check({name, "_done_seen"}, done, 1);
    end
    // start held across the done cycle must not launch another frame
    if (pulses) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    check({name, "_ss_low"},   ss_low_total - b_ss,   nframes * FRAME_LOW);
    check({name, "_busy"},     busy_total - b_busy,   nframes * FRAME_LOW);
    check({name, "_nvalid"},   rxv_total - b_rxv,     nframes * NB);
    check({name, "_ndone"},    done_total - b_done,   nframes);
    check({name, "_nphases"},  runs_total - b_runs,   nframes * RUNS);
    check({name, "_badphase"}, bad_runs - b_bad,      0);
    check({name, "_sck_idle"}, sck_tog_ss_high - b_tog, 0);
    check({name, "_done_ss"},  done_bad - b_dbad,     0);
    check({name, "_vld_1cyc"}, rxv_double - b_dbl,    0);
    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < NB; i++) begin
        k = b_rxv + f * NB + i;
        check($sformatf("%s_f%0d_byte%0d", name, f, i),
              {20'd0, got_idx[k], got_data[k]}, {20'd0, 4'(i), exp_bytes[i]});
      end
    if (nframes > 1) check({name, "_gap"}, last_gap, 2);
  endtask

  task automatic abort_frame();
    int b_rxv, b_done, cyc, rises;
    logic prev;
    b_rxv = rxv_total; b_done = done_total;
    random_bytes();
    load_slave();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; cyc = 0; prev = SCK;
    while (rises < 6 && cyc < 3 * FRAME_LOW) begin
      @(negedge clk);
      cyc++;
      if (SCK && !prev) rises++;
      prev = SCK;
    end
    check("abort_reach_bit5", rises, 6);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ss",      SS, 1);
    check("abort_sck",     SCK, 0);
    check("abort_busy",    busy, 0);
    check("abort_rx_data", rx_data, 0);
    check("abort_rx_idx",  rx_index, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_valid", rxv_total - b_rxv, 0);
    check("abort_no_done",  done_total - b_done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss",       SS, 1);
    check("rst_sck",      SCK, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data",  rx_data, 0);
    check("rst_rx_index", rx_index, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NB; i++)
      exp_bytes[i] = (i < 8) ? 8'(i + 1) : 8'(8'h11 + i - 8);
    run_frames("pattern", 1, 1'b0, 1'b0);
    check("pattern_idx13", got_data[rxv_total - NB + 13], 8'h16);

    abort_frame();
    random_bytes();
    run_frames("after_abort", 1, 1'b0, 1'b0);

    for (int i = 0; i < NB; i++) exp_bytes[i] = 8'hFF;
    run_frames("ones", 1, 1'b0, 1'b0);
    check("ones_hold", rx_data, 8'hFF);
    for (int i = 0; i < NB; i++) exp_bytes[i] = 8'h00;
    run_frames("zeros", 1, 1'b0, 1'b0);
    check("zeros_hold", rx_data, 8'h00);

    random_bytes();
    run_frames("b2b", 2, 1'b1, 1'b0);
    random_bytes();
    run_frames("pulses", 1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
